// File: rtl/inst_encoder.sv
// inst_encoder: turns encode requests into 32-bit MIPS-style instruction
// words and writes them sequentially into instruction memory, one word
// per two cycles (accept, then write).
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_kind,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_rd,
  input  logic [15:0]   req_imm,
  input  logic [25:0]   req_target,
  input  logic          finish,
  output logic          im_we,
  output logic [31:0]   im_addr,
  output logic [31:0]   im_wdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          err,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          err_reg, err_next;
  logic [31:0]   addr_reg, wdata_reg;
  logic [31:0]   word_next;
  logic          legal_next;
  logic          load_next;
  logic          handshake;

  // Outputs derive from registered state; reset forces them through state/count.
  // rst_n gates ready so it reads 0 while reset is held.
  assign full      = (count_reg == CW'(DEPTH));
  assign req_ready = rst_n && (state_reg == IDLE) && !full;
  assign handshake = req_valid && req_ready;
  assign im_we     = (state_reg == WRITE);
  assign done      = (state_reg == DONE);
  assign im_addr   = addr_reg;
  assign im_wdata  = wdata_reg;
  assign count     = count_reg;
  assign err       = err_reg;

  // Instruction encoder: format selected by kind, illegal kinds flagged.
  always_comb begin
    word_next  = 32'h0;
    legal_next = 1'b1;
    case (req_kind)
      4'd0:    word_next = {6'h00, req_rs, req_rt, req_rd, 5'b00000, 6'h20};
      4'd1:    word_next = {6'h00, req_rs, req_rt, req_rd, 5'b00000, 6'h22};
      4'd2:    word_next = {6'h00, req_rs, req_rt, req_rd, 5'b00000, 6'h24};
      4'd3:    word_next = {6'h00, req_rs, req_rt, req_rd, 5'b00000, 6'h25};
      4'd4:    word_next = {6'h00, req_rs, req_rt, req_rd, 5'b00000, 6'h2A};
      4'd5:    word_next = {6'h23, req_rs, req_rt, req_imm};
      4'd6:    word_next = {6'h2B, req_rs, req_rt, req_imm};
      4'd7:    word_next = {6'h04, req_rs, req_rt, req_imm};
      4'd8:    word_next = {6'h08, req_rs, req_rt, req_imm};
      4'd9:    word_next = {6'h02, req_target};
      default: legal_next = 1'b0;
    endcase
  end

  // Next-state logic: accept -> write one word -> back to idle; finish parks in DONE.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    err_next   = err_reg;
    load_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          if (legal_next) begin
            state_next = WRITE;
            load_next  = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end else if (finish) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        state_next = IDLE;
        count_next = count_reg + CW'(1);
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // State, counter and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  // Write address/data captured at acceptance; held steady outside WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
    end else if (load_next) begin
      addr_reg  <= BASE_ADDR + (32'(count_reg) << 2);
      wdata_reg <= word_next;
    end
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction-memory word written.
REQ-002 Parameter DEPTH, default 64, maximum number of words written; CW = $clog2(DEPTH+1).
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  encode request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_kind  input  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J; 10-15 illegal.
REQ-008 req_rs, req_rt, req_rd  input  5 each  register fields.
REQ-009 req_imm  input  16  immediate/offset field.
REQ-010 req_target  input  26  jump target field.
REQ-011 finish  input  1  close the program; no further requests accepted.
REQ-012 im_we  output  1  instruction-memory write strobe.
REQ-013 im_addr  output  32  byte address of the write.
REQ-014 im_wdata  output  32  encoded instruction word.
REQ-015 count  output  CW  number of words written since reset.
REQ-016 full  output  1  count == DEPTH.
REQ-017 err  output  1  sticky, illegal req_kind seen.
REQ-018 done  output  1  finish accepted.

Function
REQ-019 FSM states IDLE, WRITE, DONE shall be implemented; reset state IDLE.
REQ-020 req_ready shall equal (state==IDLE) && !full; it is combinational from state and count only, never from req_valid.
REQ-021 Handshake occurs when req_valid && req_ready at a rising edge; request fields shall be sampled only at that edge.
REQ-022 On a handshake with a legal kind, the encoded word shall be registered and the FSM shall enter WRITE.
REQ-023 Encoding: R-type (kinds 0-4) = {6'b000000, rs, rt, rd, 5'b00000, funct}, funct ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, SLT 6'h2A.
REQ-024 I-type = {op, rs, rt, imm}, op LW 6'h23, SW 6'h2B, BEQ 6'h04, ADDI 6'h08.
REQ-025 J-type = {6'h02, target}; rs/rt/rd/imm ignored for J, rd/target ignored for I-type.
REQ-026 In WRITE, im_we shall be 1 for exactly one cycle, im_addr = BASE_ADDR + 4*count (32-bit wrap), im_wdata = registered word; at the end of that cycle count increments by 1 and the FSM returns to IDLE.
REQ-027 Latency: handshake at edge N gives im_we high during the cycle following N; sustained throughput is one word per 2 cycles.
REQ-028 Outside WRITE, im_we shall be 0; im_addr and im_wdata hold their last values.
REQ-029 Illegal kind on handshake: err shall set at that edge and stay 1 until reset, no write, count unchanged, FSM stays IDLE.
REQ-030 full: when count reaches DEPTH, req_ready shall be 0 and count shall never exceed DEPTH; finish is still honoured.
REQ-031 finish sampled in IDLE with no handshake at that edge shall move the FSM to DONE; done = 1 and req_ready = 0 until reset.
REQ-032 finish and a handshake at the same edge: the request wins and finish is ignored; finish asserted during WRITE is ignored.

Reset
REQ-033 While rst_n = 0, all outputs shall be forced immediately: im_we 0, im_addr 0, im_wdata 0, count 0, full 0, err 0, done 0, req_ready 0, and state shall be IDLE.
REQ-034 Reset asserted mid-WRITE shall drop im_we without waiting for a clock edge; the interrupted word does not count.
REQ-035 req_ready shall be 1 on the first clock cycle after rst_n deasserts.

Verification
REQ-036 ADD rs=1 rt=2 rd=3 -> one im_we pulse, im_addr 0x00000000, im_wdata 0x00221820, count 1.
REQ-037 LW rs=0 rt=8 imm=4, then BEQ rs=1 rt=2 imm=0xFFFF, then J target=0x100 -> im_wdata 0x8C080004 @0x0, 0x1022FFFF @0x4, 0x08000100 @0x8; req_ready low for each WRITE cycle.
REQ-038 kind=12 handshake -> err 1, no im_we, count unchanged; a following SUB rs=4 rt=5 rd=6 still writes 0x00853022.
REQ-039 DEPTH=4, six back-to-back requests -> exactly 4 writes, full 1, req_ready 0, count 4.
REQ-040 finish together with a handshake -> word written, done 0; a later lone finish -> done 1, req_ready 0 permanently.
REQ-041 rst_n pulled low mid-WRITE -> im_we 0 asynchronously, count 0, err 0, done 0; normal operation resumes after release.
